// File: rtl/vedic_mult_arbiter.sv
// Round-robin arbiter sharing one Vedic 8x8 multiplier among NUM_REQ requesters.
// Define VEDIC_ARB_OUTREG_EN to add a second output register stage (latency 2).

module vedicmultiplier_8bit (
  input  logic [7:0]  i_a,
  input  logic [7:0]  i_b,
  output logic [15:0] o_p
);
  logic [7:0] w_ll;
  logic [7:0] w_lh;
  logic [7:0] w_hl;
  logic [7:0] w_hh;

  // Vertical-and-crosswise split into four 4x4 partial products.
  assign w_ll = {4'b0000, i_a[3:0]} * {4'b0000, i_b[3:0]};
  assign w_lh = {4'b0000, i_a[3:0]} * {4'b0000, i_b[7:4]};
  assign w_hl = {4'b0000, i_a[7:4]} * {4'b0000, i_b[3:0]};
  assign w_hh = {4'b0000, i_a[7:4]} * {4'b0000, i_b[7:4]};
  assign o_p  = {w_hh, w_ll} + ({8'h00, w_lh} << 4'd4) + ({8'h00, w_hl} << 4'd4);
endmodule

module vedic_mult_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_A,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_B,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [2*DATA_WIDTH-1:0]       rsp_data,
  output logic                          busy
);
  logic [ID_W-1:0]         r_ptr;
  logic [ID_W-1:0]         w_gnt;
  logic                    w_found;
  logic                    w_adv;
  logic                    w_acc;
  logic                    w_final_vld;
  logic [DATA_WIDTH-1:0]   w_a;
  logic [DATA_WIDTH-1:0]   w_b;
  logic [2*DATA_WIDTH-1:0] w_prod;
  logic                    r_s1_vld;
  logic [ID_W-1:0]         r_s1_id;
  logic [2*DATA_WIDTH-1:0] r_s1_data;

  // Round-robin search starting at r_ptr, first valid requester wins.
  always_comb begin
    logic [ID_W-1:0] v_idx;
    v_idx   = '0;
    w_found = 1'b0;
    w_gnt   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      v_idx = ID_W'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_found && req_valid[v_idx]) begin
        w_found = 1'b1;
        w_gnt   = v_idx;
      end else begin
        w_gnt   = w_gnt;
      end
    end
  end

  // The whole pipeline moves only when the final stage can empty.
  assign w_adv = !w_final_vld || rsp_ready;
  assign w_acc = w_found && w_adv && rst_n;

  // One-hot ready for the granted requester; held low during reset.
  always_comb begin
    req_ready = '0;
    if (w_acc) begin
      req_ready[w_gnt] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  assign w_a = req_A[int'(w_gnt)*DATA_WIDTH +: DATA_WIDTH];
  assign w_b = req_B[int'(w_gnt)*DATA_WIDTH +: DATA_WIDTH];

  vedicmultiplier_8bit u_mul (
    .i_a (w_a),
    .i_b (w_b),
    .o_p (w_prod)
  );

  // Priority pointer moves past the winner only on an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_acc) begin
      r_ptr <= (w_gnt == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt + ID_W'(1);
    end else begin
      r_ptr <= r_ptr;
    end
  end

  // Product stage: loads on accept, frees when advancing without a new accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_id   <= '0;
      r_s1_data <= '0;
    end else if (w_adv) begin
      r_s1_vld <= w_acc;
      if (w_acc) begin
        r_s1_id   <= w_gnt;
        r_s1_data <= w_prod;
      end
    end
  end

`ifdef VEDIC_ARB_OUTREG_EN
  logic                    r_o_vld;
  logic [ID_W-1:0]         r_o_id;
  logic [2*DATA_WIDTH-1:0] r_o_data;

  // Output stage isolates the multiplier path from the response port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_o_vld  <= 1'b0;
      r_o_id   <= '0;
      r_o_data <= '0;
    end else if (w_adv) begin
      r_o_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_o_id   <= r_s1_id;
        r_o_data <= r_s1_data;
      end
    end
  end

  assign w_final_vld = r_o_vld;
  assign rsp_valid   = r_o_vld;
  assign rsp_id      = r_o_id;
  assign rsp_data    = r_o_data;
  assign busy        = r_s1_vld | r_o_vld;
`else
  assign w_final_vld = r_s1_vld;
  assign rsp_valid   = r_s1_vld;
  assign rsp_id      = r_s1_id;
  assign rsp_data    = r_s1_data;
  assign busy        = r_s1_vld;
`endif
endmodule

// File: tb/tb_vedic_mult_arbiter.sv
// Directed, table-driven bench for vedic_mult_arbiter (default single-stage build).
module tb_vedic_mult_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_A;
  logic [31:0] req_B;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        rr;
    logic [3:0]  exp_ready;
    logic        exp_vld;
    logic [1:0]  exp_id;
    logic [15:0] exp_data;
  } vec_t;

  vec_t tbl [13];

  vedic_mult_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_A     (req_A),
    .req_B     (req_B),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b, input logic rr);
    req_valid = v;
    req_A     = a;
    req_B     = b;
    rsp_ready = rr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle, check combinational ready, clock, check the response.
  task automatic run_cycle(input string tag, input vec_t v);
    drive(v.valid, v.a, v.b, v.rr);
    #1;
    chk({tag, " req_ready"}, 32'(req_ready), 32'(v.exp_ready));
    step();
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(v.exp_vld));
    if (v.exp_vld) begin
      chk({tag, " rsp_id"}, 32'(rsp_id), 32'(v.exp_id));
      chk({tag, " rsp_data"}, 32'(rsp_data), 32'(v.exp_data));
    end
  endtask

  initial begin
    vec_t hv;
    // all four valid from reset: grants 0,1,2,3
    tbl[0]  = '{4'b1111, 32'h04030201, 32'h10101010, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h0010};
    tbl[1]  = '{4'b1111, 32'h04030201, 32'h10101010, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h0020};
    tbl[2]  = '{4'b1111, 32'h04030201, 32'h10101010, 1'b1, 4'b0100, 1'b1, 2'd2, 16'h0030};
    tbl[3]  = '{4'b1111, 32'h04030201, 32'h10101010, 1'b1, 4'b1000, 1'b1, 2'd3, 16'h0040};
    // requesters 1 and 3 alternate from pointer 0
    tbl[4]  = '{4'b1010, 32'h0A000500, 32'h03000700, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h0023};
    tbl[5]  = '{4'b1010, 32'h0A000500, 32'h03000700, 1'b1, 4'b1000, 1'b1, 2'd3, 16'h001E};
    tbl[6]  = '{4'b1010, 32'h0A000500, 32'h03000700, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h0023};
    tbl[7]  = '{4'b1010, 32'h0A000500, 32'h03000700, 1'b1, 4'b1000, 1'b1, 2'd3, 16'h001E};
    // 0xFF*0xFF from requester 2, then an idle drain
    tbl[8]  = '{4'b0100, 32'h00FF0000, 32'h00FF0000, 1'b1, 4'b0100, 1'b1, 2'd2, 16'hFE01};
    tbl[9]  = '{4'b0000, 32'h00000000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0000};
    // boundary operands: 0*0xAB and 0x80*2 (pointer at 3 wraps to 0)
    tbl[10] = '{4'b0001, 32'h00000000, 32'h000000AB, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h0000};
    tbl[11] = '{4'b0010, 32'h00008000, 32'h00000200, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h0100};
    // full stage with rsp_ready low blocks a new request
    tbl[12] = '{4'b0001, 32'h0000000C, 32'h0000000D, 1'b0, 4'b0000, 1'b1, 2'd1, 16'h0100};

    rst_n = 1'b0;
    drive(4'b1111, 32'h04030201, 32'h10101010, 1'b1);
    #2;
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_id", 32'(rsp_id), 32'd0);
    chk("reset rsp_data", 32'(rsp_data), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b0000, 32'h0, 32'h0, 1'b1);
    step();

    for (int i = 0; i < 13; i++) begin
      run_cycle($sformatf("vec%0d", i), tbl[i]);
    end

    // Release the stall: pending 12*13 from requester 0 loads as the old product drains.
    run_cycle("stall_load", '{4'b0001, 32'h0000000C, 32'h0000000D, 1'b1, 4'b0001, 1'b1, 2'd0, 16'd156});
    for (int i = 0; i < 5; i++) begin
      run_cycle($sformatf("stall%0d", i), '{4'b0100, 32'h00030000, 32'h00050000, 1'b0, 4'b0000, 1'b1, 2'd0, 16'd156});
    end
    run_cycle("stall_release", '{4'b0100, 32'h00030000, 32'h00050000, 1'b1, 4'b0100, 1'b1, 2'd2, 16'h000F});
    run_cycle("drain", '{4'b0000, 32'h0, 32'h0, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0000});
    chk("drain busy", 32'(busy), 32'd0);

    // Reset while a product is in flight.
    hv = '{4'b0001, 32'h00000007, 32'h00000009, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h003F};
    run_cycle("pre_reset", hv);
    chk("pre_reset busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    drive(4'b1110, 32'h04030201, 32'h10101010, 1'b1);
    #1;
    chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst rsp_id", 32'(rsp_id), 32'd0);
    chk("midrst rsp_data", 32'(rsp_data), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("postrst no stale", 32'(rsp_valid), 32'd0);
    run_cycle("postrst grant", '{4'b1110, 32'h04030201, 32'h10101010, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h0020});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
